// File: rtl/result_collector.sv
// Snapshots the PE-array accumulator matrix on capture and streams it out row-major over valid/ready.
// Define RESULT_COLLECTOR_SATURATE_EN to saturate ACC_W->OUT_W instead of truncating.
module result_collector #(
  parameter int N     = 4,
  parameter int ACC_W = 20,
  parameter int OUT_W = 16,
  parameter int LOG_N = $clog2(N)
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             capture_i,
  input  logic [N-1:0][N-1:0][ACC_W-1:0]   acc_i,
  output logic                             ready_o,
  output logic                             data_valid_o,
  input  logic                             data_ready_i,
  output logic [OUT_W-1:0]                 data_o,
  output logic [LOG_N-1:0]                 row_o,
  output logic [LOG_N-1:0]                 col_o,
  output logic                             last_o,
  output logic                             overrun_o
);

  localparam int KW = 2 * LOG_N;
  localparam logic [KW-1:0] K_LAST = '1;

  typedef enum logic {S_IDLE, S_DRAIN} state_t;

  state_t                           state_q, state_d;
  logic [KW-1:0]                    k_q, k_d;
  logic                             overrun_q, overrun_d;
  logic [N-1:0][N-1:0][ACC_W-1:0]   snap_q;
  logic [ACC_W-1:0]                 sel;
  logic [OUT_W-1:0]                 conv;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      overrun_q <= overrun_d;
    end
  end

  // Snapshot has no reset: contents are meaningless until the first capture.
  always_ff @(posedge clk_i) begin
    if (state_q == S_IDLE && capture_i) begin
      snap_q <= acc_i;
    end
  end

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    overrun_d = overrun_q;
    case (state_q)
      S_IDLE: begin
        if (capture_i) begin
          state_d = S_DRAIN;
          k_d     = '0;
        end
      end
      S_DRAIN: begin
        if (capture_i) begin
          overrun_d = 1'b1;
        end
        if (data_ready_i) begin
          if (k_q == K_LAST) begin
            k_d     = '0;
            state_d = S_IDLE;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        k_d     = '0;
      end
    endcase
  end

  assign row_o = k_q[KW-1:LOG_N];
  assign col_o = k_q[LOG_N-1:0];
  assign sel   = snap_q[row_o][col_o];

`ifdef RESULT_COLLECTOR_SATURATE_EN
  localparam logic signed [ACC_W-1:0] SAT_HI = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_LO = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  always_comb begin
    conv = sel[OUT_W-1:0];
    if ($signed(sel) > SAT_HI) begin
      conv = SAT_HI[OUT_W-1:0];
    end else if ($signed(sel) < SAT_LO) begin
      conv = SAT_LO[OUT_W-1:0];
    end
  end
`else
  logic unused_sel;
  assign unused_sel = ^{1'b0, sel};
  assign conv       = sel[OUT_W-1:0];
`endif

  assign ready_o      = (state_q == S_IDLE);
  assign data_valid_o = (state_q == S_DRAIN);
  assign data_o       = data_valid_o ? conv : '0;
  assign last_o       = data_valid_o && (k_q == K_LAST);
  assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_result_collector.sv
// Self-checking bench for result_collector: vector table, random drains against a queue model, corner sequences.
module tb_result_collector;
  localparam int N     = 4;
  localparam int ACC_W = 20;
  localparam int OUT_W = 16;
  localparam int LOG_N = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic capture = 1'b0;
  logic dready = 1'b0;
  logic [N-1:0][N-1:0][ACC_W-1:0] acc = '0;
  logic ready_o, data_valid_o, last_o, overrun_o;
  logic [OUT_W-1:0] data_o;
  logic [LOG_N-1:0] row_o, col_o;

  result_collector #(.N(N), .ACC_W(ACC_W), .OUT_W(OUT_W)) dut (
    .clk_i(clk), .rst_i(rst), .capture_i(capture), .acc_i(acc),
    .ready_o(ready_o), .data_valid_o(data_valid_o), .data_ready_i(dready),
    .data_o(data_o), .row_o(row_o), .col_o(col_o), .last_o(last_o),
    .overrun_o(overrun_o)
  );

  always #5 clk = ~clk;

  typedef struct { int row; int col; int data; } beat_t;
  typedef struct { int acc; int exp_t; int exp_s; } wvec_t;

  int passed = 0;
  int total  = 0;
  beat_t q[$];
  int mat[N][N];
  wvec_t wv[16];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int conv_ref(input int v);
    int lim;
    int r;
    lim = 1 << (OUT_W - 1);
`ifdef RESULT_COLLECTOR_SATURATE_EN
    if (v > lim - 1) return lim - 1;
    if (v < -lim) return -lim;
    return v;
`else
    r = ((v % (2 * lim)) + 2 * lim) % (2 * lim);
    if (r >= lim) r -= 2 * lim;
    return r;
`endif
  endfunction

  function automatic int dout();
    return int'($signed(data_o));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_junk();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        acc[r][c] = ACC_W'($urandom);
  endtask

  task automatic random_mat();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        mat[r][c] = int'($urandom_range(0, (1 << ACC_W) - 1)) - (1 << (ACC_W - 1));
  endtask

  task automatic do_capture();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        acc[r][c] = ACC_W'(mat[r][c]);
    capture = 1'b1;
    step();
    capture = 1'b0;
    drive_junk();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        q.push_back('{r, c, conv_ref(mat[r][c])});
    check("cap_valid", int'(data_valid_o), 1);
    check("cap_ready", int'(ready_o), 0);
  endtask

  // mode 0: always ready, 1: ready pattern 1,0,0 repeating, 2: random ready
  task automatic drain(input int mode, input int cap_beat, input bit cap_last);
    int beats;
    int cyc;
    int budget;
    bit go;
    bit inj;
    beats = 0;
    cyc = 0;
    budget = 400;
    while (q.size() > 0 && budget > 0) begin
      budget--;
      check("valid", int'(data_valid_o), 1);
      check("busy_ready", int'(ready_o), 0);
      check("row", int'(row_o), q[0].row);
      check("col", int'(col_o), q[0].col);
      check("data", dout(), q[0].data);
      check("last", int'(last_o), (q.size() == 1) ? 1 : 0);
      case (mode)
        0: go = 1'b1;
        1: go = (cyc % 3 == 0);
        default: go = ($urandom_range(0, 1) == 1);
      endcase
      inj = 1'b0;
      if (beats == cap_beat && !inj) inj = 1'b1;
      if (cap_last && go && q.size() == 1) inj = 1'b1;
      if (inj) begin
        drive_junk();
        capture = 1'b1;
      end
      dready = go;
      step();
      capture = 1'b0;
      cyc++;
      if (go) begin
        void'(q.pop_front());
        beats++;
      end
      if (inj) check("overrun_set", int'(overrun_o), 1);
      if (beats == cap_beat) cap_beat = -1;
    end
    check("drain_done", q.size(), 0);
    dready = 1'b0;
    check("end_ready", int'(ready_o), 1);
    check("end_valid", int'(data_valid_o), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    wv = '{
      '{ 40000, -25536,  32767}, '{-40000,  25536, -32768},
      '{     0,      0,      0}, '{     1,      1,      1},
      '{    -1,     -1,     -1}, '{ 32767,  32767,  32767},
      '{-32768, -32768, -32768}, '{ 32768, -32768,  32767},
      '{-32769,  32767, -32768}, '{ 65535,     -1,  32767},
      '{ 65536,      0,  32767}, '{524287,     -1,  32767},
      '{-524288,     0, -32768}, '{   100,    100,    100},
      '{  -100,   -100,   -100}, '{ 12345,  12345,  12345}
    };

    // Reset and idle
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", int'(ready_o), 1);
    check("rst_valid", int'(data_valid_o), 0);
    check("rst_overrun", int'(overrun_o), 0);
    check("rst_data", dout(), 0);
    check("rst_row", int'(row_o), 0);
    check("rst_col", int'(col_o), 0);
    check("rst_last", int'(last_o), 0);
    rst = 1'b0;
    drive_junk();
    for (int i = 0; i < 3; i++) begin
      step();
      check("idle_valid", int'(data_valid_o), 0);
      check("idle_ready", int'(ready_o), 1);
    end

    // Basic drain, acc[r][c] = 16r + c
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        mat[r][c] = 16 * r + c;
    do_capture();
    drain(0, -1, 1'b0);

    // Width conversion table
    for (int i = 0; i < 16; i++) mat[i / N][i % N] = wv[i].acc;
    do_capture();
    q.delete();
    dready = 1'b1;
    for (int i = 0; i < 16; i++) begin
`ifdef RESULT_COLLECTOR_SATURATE_EN
      check("wconv", dout(), wv[i].exp_s);
`else
      check("wconv", dout(), wv[i].exp_t);
`endif
      check("wconv_last", int'(last_o), (i == 15) ? 1 : 0);
      step();
    end
    dready = 1'b0;
    check("wconv_done", int'(ready_o), 1);

    // Backpressure pattern, then random ready
    random_mat();
    do_capture();
    drain(1, -1, 1'b0);
    for (int n = 0; n < 3; n++) begin
      random_mat();
      do_capture();
      drain(2, -1, 1'b0);
    end
    check("no_overrun_yet", int'(overrun_o), 0);

    // Overrun at beat 5 and in the final-handshake cycle
    random_mat();
    do_capture();
    drain(0, 5, 1'b1);
    random_mat();
    do_capture();
    drain(2, -1, 1'b0);
    check("overrun_sticky", int'(overrun_o), 1);
    rst = 1'b1;
    #1;
    check("overrun_cleared", int'(overrun_o), 0);
    rst = 1'b0;
    step();

    // Reset mid-drain after 7 handshakes
    random_mat();
    do_capture();
    dready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      void'(q.pop_front());
    end
    dready = 1'b0;
    check("mid_row", int'(row_o), 1);
    check("mid_col", int'(col_o), 3);
    #2;
    rst = 1'b1;
    #1;
    check("async_valid", int'(data_valid_o), 0);
    check("async_ready", int'(ready_o), 1);
    #1;
    rst = 1'b0;
    q.delete();
    step();
    check("post_rst_valid", int'(data_valid_o), 0);
    check("post_rst_row", int'(row_o), 0);
    check("post_rst_col", int'(col_o), 0);
    random_mat();
    do_capture();
    drain(0, -1, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/result_collector.md
# result_collector

Drains the N×N accumulator outputs of the processing-element array after the `controller` finishes a matrix pass. It snapshots all N*N accumulators in one cycle, then streams them out one element per beat in row-major order over a valid/ready interface. It signals the `controller` through `ready_o` when the array may be reused. It sits between the PE array and the downstream result sink, and is the reading end of the array that the `controller` writes.

## Interface
- `N`, 4: array dimension; must be ≥2 and a power of two.
- `ACC_W`, 20: width of each signed accumulator from the array.
- `OUT_W`, 16: width of each signed output element; must be ≤ `ACC_W`.
- `LOG_N`, $clog2(N): derived; do not override.

- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `capture_i`  in  1  single-cycle pulse from `controller`: accumulators are final.
- `acc_i`  in  [N][N]×ACC_W  accumulator matrix `acc_i[row][col]`, signed.
- `ready_o`  out  1  high in IDLE; the `controller` may start the next pass.
- `data_valid_o`  out  1  output element valid.
- `data_ready_i`  in  1  downstream accepts the element.
- `data_o`  out  OUT_W  element value, signed.
- `row_o`, `col_o`  out  LOG_N each  element coordinates.
- `last_o`  out  1  high with element (N-1, N-1).
- `overrun_o`  out  1  sticky error: `capture_i` was received while not in IDLE.

## Operation
- States:
  - S_IDLE: `ready_o`=1, `data_valid_o`=0.
  - S_DRAIN: `ready_o`=0, `data_valid_o`=1.
- S_IDLE → S_DRAIN on `capture_i`=1:
  - all of `acc_i` is latched into the internal snapshot buffer.
  - element counter `k` (2*LOG_N bits) is cleared to 0.
- In S_DRAIN, output element `k` is defined as:
  - `row_o`=k[2*LOG_N-1:LOG_N], `col_o`=k[LOG_N-1:0].
  - `data_o`=conv(buf[row][col]).
  - `last_o`=(k==N*N-1).
- A handshake occurs when `data_valid_o` && `data_ready_i`:
  - if `k` < N*N-1, `k` increments.
  - if `k`==N*N-1, `k` wraps to 0 and the state returns to S_IDLE.
- While `data_valid_o`=1 and `data_ready_i`=0, all of `data_o`/`row_o`/`col_o`/`last_o` hold stable.
- `capture_i` in S_DRAIN:
  - the pulse is ignored; the buffer and counter are unchanged.
  - `overrun_o` is set and stays set until reset.
  - This includes the cycle of the final handshake, because the state is still S_DRAIN in that cycle.
- `acc_i` is sampled only on the accepted capture edge; changes at any other time have no effect.
- The snapshot buffer is not cleared by reset; its contents are don't-care until the first capture.
- conv() truncates by default and saturates when the Configuration macro is defined.

## Timing
- Reset values: state S_IDLE, `ready_o`=1, `data_valid_o`=0, `data_o`=0, `row_o`=0, `col_o`=0, `last_o`=0, `overrun_o`=0, `k`=0.
- Reset takes effect asynchronously. Asserting reset mid-drain drops `data_valid_o` immediately, without waiting for a clock edge; the partial drain is abandoned.
- Capture latency: if `capture_i` is high at edge t, then from edge t onward `data_valid_o`=1 and `ready_o`=0, presenting element (0,0).
- Throughput: one element per cycle while `data_ready_i` is held high. A full drain takes N*N cycles minimum.
- After the final handshake at edge t:
  - from edge t, `ready_o`=1 and `data_valid_o`=0.
  - the earliest next accepted `capture_i` is at edge t+1.
- All outputs are driven from registers or from the registered buffer and counter. There is no combinational path from `data_ready_i` to any output.

## Configuration
- `RESULT_COLLECTOR_SATURATE_EN`:
  - Defined: conv() saturates the signed ACC_W value to the signed OUT_W range, i.e. values > 2^(OUT_W-1)-1 output 2^(OUT_W-1)-1 and values < -2^(OUT_W-1) output -2^(OUT_W-1).
  - Not defined: conv() returns the low OUT_W bits (two's-complement wrap).
  - When OUT_W==ACC_W the two behaviours are identical.

## Test plan
- Reset then idle: `ready_o`=1, `data_valid_o`=0, `overrun_o`=0; no output until the first capture.
- Basic drain, N=4: capture with acc[r][c]=16r+c and `data_ready_i`=1 → 16 beats with data 0,1,2,3,16,…,51; `last_o` only on (3,3); `ready_o` returns to 1 on the cycle after the last beat.
- Backpressure: toggle `data_ready_i` 1,0,0,1,… → every element appears exactly once, in order, with outputs held while ready is low.
- Overrun: pulse `capture_i` at beat 5, and again in the final-handshake cycle → outputs unchanged, `overrun_o`=1 and sticky until reset.
- Width conversion, ACC_W=20, OUT_W=16, acc=40000 and -40000:
  - with macro → 32767 and -32768.
  - without macro → -25536 and 25536.
- Reset mid-drain at beat 7 → `data_valid_o` falls without waiting for a clock edge; after release the block is in IDLE with `k`=0, and the next capture drains from (0,0).
